// File: rtl/opcodes_pkg.sv
// Shared RV32 opcode constants and the load-writeback FSM encoding for the
// MEM/WB stage.
package opcodes_pkg;

  localparam logic [31:0] NOP           = 32'h0000_0013;

  localparam logic [6:0]  LW_OPCODE     = 7'b0000011;
  localparam logic [6:0]  SW_OPCODE     = 7'b0100011;
  localparam logic [6:0]  LUI_OPCODE    = 7'b0110111;
  localparam logic [6:0]  AUIPC_OPCODE  = 7'b0010111;
  localparam logic [6:0]  JAL_OPCODE    = 7'b1101111;
  localparam logic [6:0]  JALR_OPCODE   = 7'b1100111;
  localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
  localparam logic [6:0]  OP_OPCODE     = 7'b0110011;
  localparam logic [6:0]  OPIMM_OPCODE  = 7'b0010011;
  localparam logic [6:0]  FENCE_OPCODE  = 7'b0001111;
  localparam logic [6:0]  SYSTEM_OPCODE = 7'b1110011;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_WAIT = 2'd1,
    LD_HOLD = 2'd2
  } load_wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Aligned load lane extraction: picks the byte/half addressed by addr and
// sign- or zero-extends it according to func3 (bit 2 set = unsigned).
module load_extend (
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] word,
  output logic [31:0] value
);

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic is_unsigned);
    return is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic is_unsigned);
    return is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
  endfunction

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = word[{addr, 3'b000} +: 8];
    lane_half = addr[1] ? word[31:16] : word[15:0];
    value     = word;
    case (func3[1:0])
      2'b00:   value = ext_byte(lane_byte, func3[2]);
      2'b01:   value = ext_half(lane_half, func3[2]);
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback unit: selects/extends load data,
// drives the register-file write port and counts retired instructions.
module mem_wb_stage
  import opcodes_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          COUNT_RETIRE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_flush_i,
  input  logic        memory_stall_i,
  input  logic [31:0] EXMEMIR_i,
  input  logic [31:0] EXMEMPC_i,
  input  logic [31:0] EXMEMALUOut_i,
  input  logic [31:0] Merged_Word_i,
  input  logic        unaligned_access_i,
  input  logic        data_memory_response_i,
  input  logic [31:0] read_data_i,
  output logic [31:0] MEMWBIR_o,
  output logic [31:0] MEMWBPC_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic        retire_o,
  output logic [63:0] instret_o
);

  load_wb_state_t state_q, state_d;
  logic [31:0]    ld_buf_q;
  logic [63:0]    instret_q;

  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [4:0]  rd;
  logic        is_load, commit, ld_latch, we_op, we_next;
  logic [31:0] ld_word, ld_ext, wb_next;

  load_extend u_load_extend (
    .func3 (func3),
    .addr  (EXMEMALUOut_i[1:0]),
    .word  (ld_word),
    .value (ld_ext)
  );

  always_comb begin
    opcode   = EXMEMIR_i[6:0];
    func3    = EXMEMIR_i[14:12];
    rd       = EXMEMIR_i[11:7];
    is_load  = (opcode == LW_OPCODE);
    commit   = !memory_stall_i && !trap_flush_i && (EXMEMIR_i != NOP);
    state_d  = state_q;
    ld_latch = 1'b0;

    // A response seen while MEM is still stalled must be parked in ld_buf,
    // because read_data_i is only valid for that one cycle.
    if (trap_flush_i || !memory_stall_i) begin
      state_d = LD_IDLE;
    end else begin
      case (state_q)
        LD_IDLE: if (is_load) begin
          if (data_memory_response_i) begin
            state_d  = LD_HOLD;
            ld_latch = 1'b1;
          end else begin
            state_d  = LD_WAIT;
          end
        end
        LD_WAIT: if (data_memory_response_i) begin
          state_d  = LD_HOLD;
          ld_latch = 1'b1;
        end
        default: state_d = state_q;
      endcase
    end

    ld_word = (state_q == LD_HOLD) ? ld_buf_q : read_data_i;
    if (is_load) begin
      wb_next = unaligned_access_i ? Merged_Word_i : ld_ext;
    end else begin
      wb_next = EXMEMALUOut_i;
    end

    case (opcode)
      LUI_OPCODE, AUIPC_OPCODE, JAL_OPCODE, JALR_OPCODE,
      OP_OPCODE, OPIMM_OPCODE, LW_OPCODE: we_op = 1'b1;
      SYSTEM_OPCODE:                      we_op = (func3 != 3'd0);
      default:                            we_op = 1'b0;
    endcase
    we_next = we_op && (rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LD_IDLE;
      MEMWBIR_o <= NOP;
      MEMWBPC_o <= RESET_PC;
      wb_rd_o   <= 5'd0;
      wb_data_o <= 32'd0;
      wb_we_o   <= 1'b0;
      retire_o  <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      state_q <= state_d;
      if (ld_latch) ld_buf_q <= read_data_i;
      // Flush squashes the MEM instruction but leaves instret untouched.
      if (trap_flush_i) begin
        MEMWBIR_o <= NOP;
        MEMWBPC_o <= RESET_PC;
        wb_rd_o   <= 5'd0;
        wb_data_o <= 32'd0;
        wb_we_o   <= 1'b0;
        retire_o  <= 1'b0;
      end else if (commit) begin
        MEMWBIR_o <= EXMEMIR_i;
        MEMWBPC_o <= EXMEMPC_i;
        wb_rd_o   <= rd;
        wb_data_o <= wb_next;
        wb_we_o   <= we_next;
        retire_o  <= 1'b1;
        if (COUNT_RETIRE) instret_q <= instret_q + 64'd1;
      end else begin
        MEMWBIR_o <= NOP;
        wb_we_o   <= 1'b0;
        retire_o  <= 1'b0;
      end
    end
  end

  assign instret_o = COUNT_RETIRE ? instret_q : 64'd0;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: each scenario pushes the expected
// writeback when it drives a commit and pops/compares one cycle later.
module tb_mem_wb_stage;
  import opcodes_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst, trap_flush_i, memory_stall_i, unaligned_access_i, data_memory_response_i;
  logic [31:0] EXMEMIR_i, EXMEMPC_i, EXMEMALUOut_i, Merged_Word_i, read_data_i;
  logic [31:0] MEMWBIR_o, MEMWBPC_o, wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o, retire_o;
  logic [63:0] instret_o;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_instret = 64'd0;

  mem_wb_stage #(.RESET_PC(RST_PC), .COUNT_RETIRE(1'b1)) dut (
    .clk(clk), .rst(rst), .trap_flush_i(trap_flush_i), .memory_stall_i(memory_stall_i),
    .EXMEMIR_i(EXMEMIR_i), .EXMEMPC_i(EXMEMPC_i), .EXMEMALUOut_i(EXMEMALUOut_i),
    .Merged_Word_i(Merged_Word_i), .unaligned_access_i(unaligned_access_i),
    .data_memory_response_i(data_memory_response_i), .read_data_i(read_data_i),
    .MEMWBIR_o(MEMWBIR_o), .MEMWBPC_o(MEMWBPC_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .wb_we_o(wb_we_o), .retire_o(retire_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    trap_flush_i = 1'b0; memory_stall_i = 1'b0; unaligned_access_i = 1'b0;
    data_memory_response_i = 1'b0; EXMEMIR_i = NOP; EXMEMPC_i = 32'h0;
    EXMEMALUOut_i = 32'h0; Merged_Word_i = 32'h0; read_data_i = 32'h0;
  endtask

  task automatic commit_push(input logic [31:0] ir, input logic [31:0] pc,
                             input logic [31:0] data, input logic we);
    sb.push_back('{ir: ir, pc: pc, rd: ir[11:7], data: data, we: we});
    exp_instret = exp_instret + 64'd1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (MEMWBIR_o !== NOP) begin n_fail++; $display("FAIL reset_ir got %h want %h", MEMWBIR_o, NOP); end
    n_cmp++; if (MEMWBPC_o !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", MEMWBPC_o, RST_PC); end
    n_cmp++; if ({wb_rd_o, wb_data_o, wb_we_o, retire_o} !== 39'd0) begin n_fail++;
      $display("FAIL reset_wb got rd=%0d data=%h we=%b ret=%b want all 0", wb_rd_o, wb_data_o, wb_we_o, retire_o); end
    n_cmp++; if (instret_o !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", instret_o); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    exp_t e;
    drive_idle();
    EXMEMIR_i = i_type(12'd7, 5'd0, 3'b000, 5'd5, OPIMM_OPCODE);
    EXMEMPC_i = 32'h0000_0200; EXMEMALUOut_i = 32'd7;
    commit_push(EXMEMIR_i, EXMEMPC_i, 32'd7, 1'b1);
    step(); drive_idle();
    e = sb.pop_front();
    n_cmp++; if (MEMWBIR_o !== e.ir) begin n_fail++; $display("FAIL addi_ir got %h want %h", MEMWBIR_o, e.ir); end
    n_cmp++; if (MEMWBPC_o !== e.pc) begin n_fail++; $display("FAIL addi_pc got %h want %h", MEMWBPC_o, e.pc); end
    n_cmp++; if (wb_rd_o !== e.rd) begin n_fail++; $display("FAIL addi_rd got %0d want %0d", wb_rd_o, e.rd); end
    n_cmp++; if (wb_data_o !== e.data) begin n_fail++; $display("FAIL addi_data got %h want %h", wb_data_o, e.data); end
    n_cmp++; if (wb_we_o !== e.we || retire_o !== 1'b1) begin n_fail++;
      $display("FAIL addi_we_ret got we=%b ret=%b want we=%b ret=1", wb_we_o, retire_o, e.we); end
    n_cmp++; if (instret_o !== exp_instret) begin n_fail++; $display("FAIL addi_instret got %0d want %0d", instret_o, exp_instret); end
    step();
    n_cmp++; if (retire_o !== 1'b0 || wb_we_o !== 1'b0 || MEMWBIR_o !== NOP) begin n_fail++;
      $display("FAIL bubble got ir=%h we=%b ret=%b want NOP/0/0", MEMWBIR_o, wb_we_o, retire_o); end
  endtask

  task automatic test_byte_loads();
    exp_t e;
    logic [2:0] f3s [2] = '{3'b000, 3'b100};
    logic [31:0] wants [2] = '{32'hFFFF_FF80, 32'h0000_0080};
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      EXMEMIR_i = i_type(12'h103, 5'd1, f3s[i], 5'd6, LW_OPCODE);
      EXMEMPC_i = 32'h0000_0300 + 32'(i * 4); EXMEMALUOut_i = 32'h0000_0103;
      data_memory_response_i = 1'b1; read_data_i = 32'h80AA_BBCC;
      commit_push(EXMEMIR_i, EXMEMPC_i, wants[i], 1'b1);
      step(); drive_idle();
      e = sb.pop_front();
      n_cmp++; if (wb_data_o !== e.data) begin n_fail++; $display("FAIL lb%0d_data got %h want %h", i, wb_data_o, e.data); end
      n_cmp++; if (wb_rd_o !== e.rd || wb_we_o !== e.we) begin n_fail++;
        $display("FAIL lb%0d_rd_we got rd=%0d we=%b want rd=%0d we=%b", i, wb_rd_o, wb_we_o, e.rd, e.we); end
    end
  endtask

  task automatic test_load_hold();
    exp_t e;
    drive_idle();
    EXMEMIR_i = i_type(12'h102, 5'd1, 3'b001, 5'd7, LW_OPCODE);
    EXMEMPC_i = 32'h0000_0400; EXMEMALUOut_i = 32'h0000_0102;
    memory_stall_i = 1'b1;
    step();
    n_cmp++; if (retire_o !== 1'b0 || MEMWBIR_o !== NOP) begin n_fail++;
      $display("FAIL lh_stall got ir=%h ret=%b want NOP/0", MEMWBIR_o, retire_o); end
    data_memory_response_i = 1'b1; read_data_i = 32'h1234_5678;
    step();
    data_memory_response_i = 1'b0; read_data_i = 32'hFFFF_0000;
    n_cmp++; if (dut.state_q !== LD_HOLD) begin n_fail++; $display("FAIL lh_state got %0d want %0d", dut.state_q, LD_HOLD); end
    step(); step();
    memory_stall_i = 1'b0;
    commit_push(EXMEMIR_i, EXMEMPC_i, 32'h0000_1234, 1'b1);
    step(); drive_idle();
    e = sb.pop_front();
    n_cmp++; if (wb_data_o !== e.data) begin n_fail++; $display("FAIL lh_hold_data got %h want %h", wb_data_o, e.data); end
    n_cmp++; if (MEMWBPC_o !== e.pc || retire_o !== 1'b1) begin n_fail++;
      $display("FAIL lh_hold_pc got pc=%h ret=%b want pc=%h ret=1", MEMWBPC_o, retire_o, e.pc); end
    n_cmp++; if (dut.state_q !== LD_IDLE) begin n_fail++; $display("FAIL lh_state_idle got %0d want %0d", dut.state_q, LD_IDLE); end
  endtask

  task automatic test_unaligned();
    exp_t e;
    drive_idle();
    EXMEMIR_i = i_type(12'h101, 5'd1, 3'b010, 5'd8, LW_OPCODE);
    EXMEMPC_i = 32'h0000_0500; EXMEMALUOut_i = 32'h0000_0101;
    unaligned_access_i = 1'b1; Merged_Word_i = 32'hDEAD_BEEF;
    data_memory_response_i = 1'b1; read_data_i = 32'h0102_0304;
    commit_push(EXMEMIR_i, EXMEMPC_i, 32'hDEAD_BEEF, 1'b1);
    step(); drive_idle();
    e = sb.pop_front();
    n_cmp++; if (wb_data_o !== e.data || wb_we_o !== e.we) begin n_fail++;
      $display("FAIL unaligned got data=%h we=%b want data=%h we=%b", wb_data_o, wb_we_o, e.data, e.we); end
  endtask

  task automatic test_no_write();
    exp_t e;
    logic [31:0] irs [2];
    irs[0] = {7'd0, 5'd2, 5'd1, 3'b010, 5'd5, SW_OPCODE};
    irs[1] = {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, OP_OPCODE};
    for (int i = 0; i < 2; i++) begin
      drive_idle();
      EXMEMIR_i = irs[i]; EXMEMPC_i = 32'h0000_0600 + 32'(i * 4); EXMEMALUOut_i = 32'h0000_0055;
      commit_push(EXMEMIR_i, EXMEMPC_i, 32'h0000_0055, 1'b0);
      step(); drive_idle();
      e = sb.pop_front();
      n_cmp++; if (wb_we_o !== e.we || retire_o !== 1'b1) begin n_fail++;
        $display("FAIL nowrite%0d got we=%b ret=%b want we=0 ret=1", i, wb_we_o, retire_o); end
      n_cmp++; if (instret_o !== exp_instret) begin n_fail++;
        $display("FAIL nowrite%0d_instret got %0d want %0d", i, instret_o, exp_instret); end
    end
  endtask

  task automatic test_flush();
    drive_idle();
    EXMEMIR_i = i_type(12'h10, 5'd1, 3'b010, 5'd9, LW_OPCODE);
    EXMEMPC_i = 32'h0000_0700; EXMEMALUOut_i = 32'h0000_0010;
    data_memory_response_i = 1'b1; read_data_i = 32'h0000_0055; trap_flush_i = 1'b1;
    step(); drive_idle();
    n_cmp++; if (MEMWBIR_o !== NOP || MEMWBPC_o !== RST_PC) begin n_fail++;
      $display("FAIL flush_ir_pc got ir=%h pc=%h want %h/%h", MEMWBIR_o, MEMWBPC_o, NOP, RST_PC); end
    n_cmp++; if (retire_o !== 1'b0 || wb_we_o !== 1'b0) begin n_fail++;
      $display("FAIL flush_ret got ret=%b we=%b want 0/0", retire_o, wb_we_o); end
    n_cmp++; if (instret_o !== exp_instret) begin n_fail++;
      $display("FAIL flush_instret got %0d want %0d", instret_o, exp_instret); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive_idle();
    for (int i = 1; i <= 3; i++) begin
      EXMEMIR_i = i_type(12'(i * 3), 5'd0, 3'b000, 5'(i), OPIMM_OPCODE);
      EXMEMPC_i = 32'h0000_0800 + 32'(i * 4); EXMEMALUOut_i = 32'(i * 3);
      commit_push(EXMEMIR_i, EXMEMPC_i, 32'(i * 3), 1'b1);
      step();
      if (sb.size() == 0) begin
        n_cmp++; n_fail++; $display("FAIL b2b_empty got empty queue want entry");
      end else begin
        e = sb.pop_front();
        n_cmp++; if (wb_rd_o !== e.rd || wb_data_o !== e.data || MEMWBPC_o !== e.pc) begin n_fail++;
          $display("FAIL b2b%0d got rd=%0d data=%h pc=%h want rd=%0d data=%h pc=%h",
                   i, wb_rd_o, wb_data_o, MEMWBPC_o, e.rd, e.data, e.pc); end
        n_cmp++; if (instret_o !== exp_instret) begin n_fail++;
          $display("FAIL b2b%0d_instret got %0d want %0d", i, instret_o, exp_instret); end
      end
    end
    drive_idle();
    step();
  endtask

  task automatic test_wrap();
    exp_t e;
    drive_idle();
    dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    EXMEMIR_i = i_type(12'd1, 5'd0, 3'b000, 5'd4, OPIMM_OPCODE);
    EXMEMPC_i = 32'h0000_0900; EXMEMALUOut_i = 32'd1;
    commit_push(EXMEMIR_i, EXMEMPC_i, 32'd1, 1'b1);
    step(); drive_idle();
    e = sb.pop_front();
    n_cmp++; if (instret_o !== 64'd0 || instret_o !== exp_instret) begin n_fail++;
      $display("FAIL wrap_instret got %h want %h", instret_o, exp_instret); end
    n_cmp++; if (retire_o !== 1'b1 || wb_data_o !== e.data) begin n_fail++;
      $display("FAIL wrap_retire got ret=%b data=%h want 1/%h", retire_o, wb_data_o, e.data); end
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    #2;
    test_reset();
    test_addi();
    test_byte_loads();
    test_load_hold();
    test_unaligned();
    test_no_write();
    test_flush();
    test_back_to_back();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
